// File: rtl/core_pkg.sv
// Shared core types and constants: PC unit states, trap causes
// and the default address map.
package core_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_t;

   localparam logic [3:0] CAUSE_INSN_MISALIGNED = 4'd0;
   localparam logic [3:0] CAUSE_INSN_FAULT      = 4'd1;
   localparam logic [3:0] CAUSE_ILLEGAL_INSN    = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT      = 4'd3;
   localparam logic [3:0] CAUSE_ECALL_M         = 4'd11;

   localparam int          XLEN_DEFAULT         = 32;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap, mret, redirect (with alignment
// check), stall, sequential step.
module pc_next_sel
   import core_pkg::*;
#(
   parameter int              XLEN        = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
   parameter int              ILEN_BYTES  = 4
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] epc,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_req,
   input  logic            mret,
   output logic [XLEN-1:0] pc_next,
   output logic            save_epc,
   output logic            misalign
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);
   localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN_BYTES);

   logic tgt_misaligned;

   assign tgt_misaligned = |(redirect_target & ALIGN_MASK);

   always_comb begin
      pc_next  = pc + STEP;
      save_epc = 1'b0;
      misalign = 1'b0;
      priority case (1'b1)
         trap_req: begin
            pc_next  = TRAP_VECTOR;
            save_epc = 1'b1;
         end
         mret: begin
            pc_next = epc;
         end
         (redirect_valid && tgt_misaligned): begin
            pc_next  = TRAP_VECTOR;
            save_epc = 1'b1;
            misalign = 1'b1;
         end
         redirect_valid: begin
            pc_next = redirect_target;
         end
         stall: begin
            pc_next = pc;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT control, PC, exception PC,
// trap cause and misalignment pulse registers.
module pc_unit
   import core_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
   parameter int              ILEN_BYTES   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_req,
   input  logic [3:0]      trap_cause_in,
   input  logic            mret,
   input  logic            halt_req,
   input  logic            resume_req,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus_ilen,
   output logic            pc_valid,
   output logic [XLEN-1:0] epc_out,
   output logic [3:0]      cause_out,
   output logic            misalign_exc,
   output logic            halted
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);
   localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN_BYTES);

   if ((ILEN_BYTES != 2 && ILEN_BYTES != 4) ||
       (|(RESET_VECTOR & ALIGN_MASK)) ||
       (|(TRAP_VECTOR & ALIGN_MASK))) begin : g_bad_cfg
      $fatal(1, "pc_unit: illegal ILEN_BYTES or unaligned vector");
   end

   pc_state_t       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [3:0]      cause_q, cause_d;
   logic            mis_q, mis_d;

   logic [XLEN-1:0] sel_pc;
   logic            sel_save;
   logic            sel_mis;

   pc_next_sel #(
      .XLEN        (XLEN),
      .TRAP_VECTOR (TRAP_VECTOR),
      .ILEN_BYTES  (ILEN_BYTES)
   ) u_sel (
      .pc              (pc_q),
      .epc             (epc_q),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_req        (trap_req),
      .mret            (mret),
      .pc_next         (sel_pc),
      .save_epc        (sel_save),
      .misalign        (sel_mis)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         cause_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         mis_q   <= mis_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN:  if (halt_req && !trap_req) state_d = HALT;
         HALT: if (resume_req) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   // Only RUN advances the PC; BOOT and HALT hold everything.
   always_comb begin
      pc_d    = pc_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      mis_d   = 1'b0;
      if (state_q == RUN) begin
         pc_d  = sel_pc;
         mis_d = sel_mis;
         if (sel_save) begin
            epc_d   = pc_q;
            cause_d = trap_req ? trap_cause_in : CAUSE_INSN_MISALIGNED;
         end
      end
   end

   always_comb begin
      pc_valid = (state_q == RUN);
      halted   = (state_q == HALT);
   end

   assign pc_out       = pc_q;
   assign pc_plus_ilen = pc_q + STEP;
   assign epc_out      = epc_q;
   assign cause_out    = cause_q;
   assign misalign_exc = mis_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V core; replaces the bare PC register.
- Owns next-PC selection: sequential increment, branch/jump redirect, trap entry, trap return (mret), stall and halt/resume.
- Latches the exception PC (epc) and cause.
- Feeds the instruction-memory address and the PC+ILEN value used for the link register.

Parameters:
- XLEN, 32, PC/address width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry.
- ILEN_BYTES, 4, instruction step and alignment in bytes; legal values are 4 only, or 2 (compressed support).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold the PC this cycle (pipeline/memory stall)
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  XLEN  branch/jump target address
- trap_req  in  1  synchronous exception/interrupt request from execute
- trap_cause_in  in  4  cause code accompanying trap_req
- mret  in  1  return from trap
- halt_req  in  1  debug halt request
- resume_req  in  1  debug resume request
- pc_out  out  XLEN  current PC (instruction-memory address)
- pc_plus_ilen  out  XLEN  pc_out + ILEN_BYTES, modulo 2^XLEN
- pc_valid  out  1  pc_out is a real fetch address this cycle
- epc_out  out  XLEN  saved exception PC
- cause_out  out  4  saved trap cause
- misalign_exc  out  1  one-cycle pulse: redirect target was misaligned
- halted  out  1  unit is in HALT state

Behaviour:
- Reset (async assert, any state): pc_out=RESET_VECTOR, epc_out=0, cause_out=0, misalign_exc=0, pc_valid=0, halted=0, state=BOOT. All inputs are ignored while rst is high.
- States: BOOT, RUN, HALT. Transitions:
  - BOOT -> RUN unconditionally on the first clk edge after reset deasserts. pc_valid=0 in BOOT; the PC is held.
  - RUN -> HALT when halt_req=1 and trap_req=0. The PC update of that same cycle still happens.
  - HALT -> RUN when resume_req=1. In HALT: pc_valid=0, halted=1, PC held, all control inputs ignored except resume_req and rst.
  - halt_req and resume_req both high in RUN: halt_req wins. Both high in HALT: resume_req wins.
- Next-PC in RUN, evaluated every edge, strict priority:
  1. trap_req: pc<=TRAP_VECTOR, epc<=pc_out, cause<=trap_cause_in.
  2. mret: pc<=epc_out; epc and cause unchanged.
  3. redirect_valid with target misaligned (target mod ILEN_BYTES != 0): pc<=TRAP_VECTOR, epc<=pc_out, cause<=4'd0 (instruction-address-misaligned), misalign_exc=1 for the next cycle only.
  4. redirect_valid, aligned: pc<=redirect_target.
  5. stall: pc held.
  6. Otherwise: pc<=pc_out+ILEN_BYTES.
- trap, mret and redirect override stall. A control transfer is never lost to a stall.
- Latency: every next-PC source is visible on pc_out one cycle after it is sampled. pc_plus_ilen is combinational from pc_out.
- Wrap-around: increment and pc_plus_ilen wrap modulo 2^XLEN (0xFFFF_FFFC + 4 = 0). No overflow flag.
- misalign_exc is registered and lasts exactly one cycle, even if stall is held.
- pc_valid=1 exactly when state==RUN.
- Reset asserted mid-operation (e.g. during HALT, or in the same cycle as a trap) returns all outputs to their reset values immediately. The trap is discarded.
- Elaboration check: ILEN_BYTES not in {2,4}, or RESET_VECTOR/TRAP_VECTOR not aligned to ILEN_BYTES, is a fatal error.

Decomposition:
- Shared package core_pkg holds:
  - the state enum pc_state_t (BOOT/RUN/HALT);
  - the cause constants (CAUSE_INSN_MISALIGNED=4'd0, others);
  - XLEN_DEFAULT, RESET_VECTOR_DEFAULT, TRAP_VECTOR_DEFAULT.
- One natural sub-module: pc_next_sel, the combinational priority mux and alignment check. The FSM, PC, epc, cause and misalign registers stay in pc_unit.

Test Plan:
- Reset, release, then 4 free-running cycles -> pc_out: 0 (BOOT, pc_valid=0), 0 (pc_valid=1), 4, 8, 12. Assert rst asynchronously mid-cycle -> pc_out=0 before the next edge.
- At pc=0x20, redirect_valid=1 to 0x80 with stall=1 -> pc_out=0x80 next cycle. Hold stall 3 cycles -> pc_out stays 0x80.
- At pc=0x40, redirect to 0x82 (ILEN_BYTES=4) -> pc_out=0x100, epc_out=0x40, cause_out=0, misalign_exc high for exactly 1 cycle. Repeat with ILEN_BYTES=2 -> pc_out=0x82, no exception.
- At pc=0x30, trap_req=1 (cause 4'd11) together with redirect_valid and mret -> pc_out=0x100, epc_out=0x30, cause_out=11. Later mret=1 -> pc_out=0x30.
- At pc=0x10, halt_req=1 -> pc_out=0x14 then frozen, halted=1, pc_valid=0. redirect_valid is ignored while halted. resume_req=1 -> next cycles 0x18, 0x1C.
- Force pc to 0xFFFF_FFFC via redirect, then one free cycle -> pc_out=0x0000_0000. pc_plus_ilen=0 while pc_out=0xFFFF_FFFC.
